// File: rtl/message_handler.sv
// Coherence message front end: sorts registered NoC traffic into request/response FIFOs,
// nacks requests that overflow, and arbitrates nacks and controller messages onto the NoC.

module message_handler_fifo #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_BITS = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             empty,
   output logic             full
);

   localparam int DEPTH = 1 << DEPTH_BITS;
   localparam logic [DEPTH_BITS-1:0] PTR_ONE  = DEPTH_BITS'(1);
   localparam logic [DEPTH_BITS:0]   CNT_ONE  = (DEPTH_BITS+1)'(1);
   localparam logic [DEPTH_BITS:0]   CNT_FULL = (DEPTH_BITS+1)'(DEPTH);

   logic [WIDTH-1:0]      mem_q [DEPTH];
   logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_BITS:0]   count_q, count_d;
   logic                  do_push;
   logic                  do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CNT_FULL);
   assign rdata   = mem_q[rd_ptr_q];
   assign do_pop  = pop & ~empty;
   // A pop frees the slot in the same edge, so a full FIFO may still accept a push.
   assign do_push = push & (~full | do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
      else if (do_pop && !do_push) count_d = count_q - CNT_ONE;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (do_push) mem_q[wr_ptr_q] <= wdata;
      end
   end

endmodule

module message_handler #(
   parameter int                 CACHE_OFFSET_BITS   = 2,
   parameter int                 DATA_WIDTH          = 32,
   parameter int                 ADDRESS_BITS        = 32,
   parameter int                 MSG_BITS            = 4,
   parameter int                 REQ_BUF_DEPTH_BITS  = 2,
   parameter int                 RESP_BUF_DEPTH_BITS = 2,
   parameter string              PARENT              = "CACHE",
   parameter int                 ID_BITS             = 3,
   parameter logic [ID_BITS-1:0] DEFAULT_DEST        = '0,
   localparam int CACHE_WIDTH = DATA_WIDTH << CACHE_OFFSET_BITS,
   localparam int BUF_WIDTH   = ID_BITS + MSG_BITS + ADDRESS_BITS + CACHE_WIDTH
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [MSG_BITS-1:0]     noc_msg_in,
   input  logic [ADDRESS_BITS-1:0] noc_address_in,
   input  logic [CACHE_WIDTH-1:0]  noc_data_in,
   input  logic [ID_BITS-1:0]      noc_src_id,
   input  logic                    packetizer_busy,
   output logic [MSG_BITS-1:0]     noc_msg_out,
   output logic [ADDRESS_BITS-1:0] noc_address_out,
   output logic [CACHE_WIDTH-1:0]  noc_data_out,
   output logic [ID_BITS-1:0]      noc_dest_id,
   input  logic [MSG_BITS-1:0]     ctrl_msg_in,
   input  logic [ADDRESS_BITS-1:0] ctrl_address_in,
   input  logic [CACHE_WIDTH-1:0]  ctrl_data_in,
   input  logic [ID_BITS-1:0]      ctrl_dest_id,
   output logic                    intf_busy,
   input  logic                    reqbuf_read,
   input  logic                    respbuf_read,
   output logic                    reqbuf_empty,
   output logic                    reqbuf_full,
   output logic                    reqbuf_valid,
   output logic                    respbuf_empty,
   output logic                    respbuf_full,
   output logic                    respbuf_valid,
   output logic [BUF_WIDTH-1:0]    reqbuf_data,
   output logic [BUF_WIDTH-1:0]    respbuf_data
);

   localparam int OUT_WIDTH = MSG_BITS + ADDRESS_BITS + CACHE_WIDTH + ID_BITS;
   localparam bit IS_CACHE  = (PARENT == "CACHE");

   localparam logic [MSG_BITS-1:0] MSG_NOMSG   = MSG_BITS'(0);
   localparam logic [MSG_BITS-1:0] MSG_GETS    = MSG_BITS'(1);
   localparam logic [MSG_BITS-1:0] MSG_GETM    = MSG_BITS'(2);
   localparam logic [MSG_BITS-1:0] MSG_PUTS    = MSG_BITS'(3);
   localparam logic [MSG_BITS-1:0] MSG_PUTM    = MSG_BITS'(4);
   localparam logic [MSG_BITS-1:0] MSG_PUTE    = MSG_BITS'(5);
   localparam logic [MSG_BITS-1:0] MSG_FWDGETS = MSG_BITS'(6);
   localparam logic [MSG_BITS-1:0] MSG_FWDGETM = MSG_BITS'(7);
   localparam logic [MSG_BITS-1:0] MSG_INV     = MSG_BITS'(8);
   localparam logic [MSG_BITS-1:0] MSG_NACKB   = MSG_BITS'(12);
   localparam logic [MSG_BITS-1:0] MSG_NACKC   = MSG_BITS'(13);
   localparam logic [MSG_BITS-1:0] NACK_CODE   = IS_CACHE ? MSG_NACKC : MSG_NACKB;

   localparam logic [OUT_WIDTH-1:0] IDLE_ENTRY =
      {MSG_NOMSG, {ADDRESS_BITS{1'b0}}, {CACHE_WIDTH{1'b0}}, DEFAULT_DEST};

   function automatic logic is_request(input logic [MSG_BITS-1:0] msg);
      if (IS_CACHE)
         return (msg == MSG_FWDGETS) || (msg == MSG_FWDGETM) || (msg == MSG_INV);
      else
         return (msg == MSG_GETS) || (msg == MSG_GETM) || (msg == MSG_PUTS) ||
                (msg == MSG_PUTM) || (msg == MSG_PUTE);
   endfunction

   logic [MSG_BITS-1:0]     in_msg_q;
   logic [ADDRESS_BITS-1:0] in_addr_q;
   logic [CACHE_WIDTH-1:0]  in_data_q;
   logic [ID_BITS-1:0]      in_src_q;
   logic [OUT_WIDTH-1:0]    out_q, out_d;

   logic                    in_is_req, in_is_resp;
   logic                    req_push, resp_push, nack_new;
   logic [BUF_WIDTH-1:0]    in_entry;
   logic [OUT_WIDTH-1:0]    nack_entry, ctrl_entry;
   logic                    ctrl_new;

   logic                    nq_push, nq_pop, nq_empty, nq_full;
   logic [OUT_WIDTH-1:0]    nq_head;
   logic                    cq_push, cq_pop, cq_empty, cq_full;
   logic [OUT_WIDTH-1:0]    cq_head;
   logic                    nack_taken, ctrl_taken;

   assign in_is_req  = (in_msg_q != MSG_NOMSG) && is_request(in_msg_q);
   assign in_is_resp = (in_msg_q != MSG_NOMSG) && !is_request(in_msg_q);
   assign in_entry   = {in_src_q, in_msg_q, in_addr_q, in_data_q};
   assign req_push   = in_is_req & ~reqbuf_full;
   assign resp_push  = in_is_resp;
   // Overflowing requests are bounced back to their sender instead of stored.
   assign nack_new   = in_is_req & reqbuf_full;
   assign nack_entry = {NACK_CODE, in_addr_q, {CACHE_WIDTH{1'b0}}, in_src_q};

   assign ctrl_new   = (ctrl_msg_in != MSG_NOMSG);
   assign ctrl_entry = {ctrl_msg_in, ctrl_address_in, ctrl_data_in, ctrl_dest_id};

   message_handler_fifo #(.WIDTH(BUF_WIDTH), .DEPTH_BITS(REQ_BUF_DEPTH_BITS)) u_req_fifo (
      .clock (clock),
      .reset (reset),
      .push  (req_push),
      .pop   (reqbuf_read),
      .wdata (in_entry),
      .rdata (reqbuf_data),
      .empty (reqbuf_empty),
      .full  (reqbuf_full)
   );

   message_handler_fifo #(.WIDTH(BUF_WIDTH), .DEPTH_BITS(RESP_BUF_DEPTH_BITS)) u_resp_fifo (
      .clock (clock),
      .reset (reset),
      .push  (resp_push),
      .pop   (respbuf_read),
      .wdata (in_entry),
      .rdata (respbuf_data),
      .empty (respbuf_empty),
      .full  (respbuf_full)
   );

   message_handler_fifo #(.WIDTH(OUT_WIDTH), .DEPTH_BITS(1)) u_nack_q (
      .clock (clock),
      .reset (reset),
      .push  (nq_push),
      .pop   (nq_pop),
      .wdata (nack_entry),
      .rdata (nq_head),
      .empty (nq_empty),
      .full  (nq_full)
   );

   message_handler_fifo #(.WIDTH(OUT_WIDTH), .DEPTH_BITS(2)) u_ctrl_q (
      .clock (clock),
      .reset (reset),
      .push  (cq_push),
      .pop   (cq_pop),
      .wdata (ctrl_entry),
      .rdata (cq_head),
      .empty (cq_empty),
      .full  (cq_full)
   );

   assign reqbuf_valid  = ~reqbuf_empty;
   assign respbuf_valid = ~respbuf_empty;

   // Queued work always wins over fresh work of the same kind, which keeps each stream in order.
   always_comb begin
      out_d      = out_q;
      nq_pop     = 1'b0;
      cq_pop     = 1'b0;
      nack_taken = 1'b0;
      ctrl_taken = 1'b0;
      if (!packetizer_busy) begin
         if (!nq_empty) begin
            out_d  = nq_head;
            nq_pop = 1'b1;
         end else if (nack_new) begin
            out_d      = nack_entry;
            nack_taken = 1'b1;
         end else if (!cq_empty) begin
            out_d  = cq_head;
            cq_pop = 1'b1;
         end else if (ctrl_new) begin
            out_d      = ctrl_entry;
            ctrl_taken = 1'b1;
         end else begin
            out_d = IDLE_ENTRY;
         end
      end
   end

   assign nq_push = nack_new & ~nack_taken & (~nq_full | nq_pop);
   assign cq_push = ctrl_new & ~ctrl_taken & (~cq_full | cq_pop);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         in_msg_q  <= '0;
         in_addr_q <= '0;
         in_data_q <= '0;
         in_src_q  <= '0;
         out_q     <= IDLE_ENTRY;
      end else begin
         in_msg_q  <= noc_msg_in;
         in_addr_q <= noc_address_in;
         in_data_q <= noc_data_in;
         in_src_q  <= noc_src_id;
         out_q     <= out_d;
      end
   end

   assign {noc_msg_out, noc_address_out, noc_data_out, noc_dest_id} = out_q;

   assign intf_busy = packetizer_busy | ~nq_empty | ~cq_empty | (noc_msg_out == NACK_CODE);

endmodule

// File: tb/tb_message_handler.sv
// Directed and randomised checks of message_handler: FIFO sorting, nacks, ctrl arbitration,
// backpressure and reset, with NoC outputs matched against an expected-output queue.

module tb_message_handler;

   localparam int OW = 4 + 32 + 128 + 3;
   localparam int BW = 3 + 4 + 32 + 128;

   logic           clock = 1'b0;
   logic           reset = 1'b1;
   logic [3:0]     noc_msg_in = '0;
   logic [31:0]    noc_address_in = '0;
   logic [127:0]   noc_data_in = '0;
   logic [2:0]     noc_src_id = '0;
   logic           packetizer_busy = 1'b0;
   logic [3:0]     noc_msg_out;
   logic [31:0]    noc_address_out;
   logic [127:0]   noc_data_out;
   logic [2:0]     noc_dest_id;
   logic [3:0]     ctrl_msg_in = '0;
   logic [31:0]    ctrl_address_in = '0;
   logic [127:0]   ctrl_data_in = '0;
   logic [2:0]     ctrl_dest_id = '0;
   logic           intf_busy;
   logic           reqbuf_read = 1'b0;
   logic           respbuf_read = 1'b0;
   logic           reqbuf_empty, reqbuf_full, reqbuf_valid;
   logic           respbuf_empty, respbuf_full, respbuf_valid;
   logic [BW-1:0]  reqbuf_data, respbuf_data;

   int             checks = 0;
   int             failures = 0;
   int             cyc = 0;
   logic           mon_en = 1'b0;
   logic [OW+15:0] exp_q[$];
   logic [BW-1:0]  req_model_q[$];
   logic [BW-1:0]  resp_model_q[$];
   logic [OW+15:0] e_word;

   message_handler #(.DEFAULT_DEST(3'd2)) dut (
      .clock           (clock),
      .reset           (reset),
      .noc_msg_in      (noc_msg_in),
      .noc_address_in  (noc_address_in),
      .noc_data_in     (noc_data_in),
      .noc_src_id      (noc_src_id),
      .packetizer_busy (packetizer_busy),
      .noc_msg_out     (noc_msg_out),
      .noc_address_out (noc_address_out),
      .noc_data_out    (noc_data_out),
      .noc_dest_id     (noc_dest_id),
      .ctrl_msg_in     (ctrl_msg_in),
      .ctrl_address_in (ctrl_address_in),
      .ctrl_data_in    (ctrl_data_in),
      .ctrl_dest_id    (ctrl_dest_id),
      .intf_busy       (intf_busy),
      .reqbuf_read     (reqbuf_read),
      .respbuf_read    (respbuf_read),
      .reqbuf_empty    (reqbuf_empty),
      .reqbuf_full     (reqbuf_full),
      .reqbuf_valid    (reqbuf_valid),
      .respbuf_empty   (respbuf_empty),
      .respbuf_full    (respbuf_full),
      .respbuf_valid   (respbuf_valid),
      .reqbuf_data     (reqbuf_data),
      .respbuf_data    (respbuf_data)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Output monitor: every non-idle NoC message must match the queue head, cycle included.
   always @(negedge clock) begin
      if (mon_en) begin
         cyc = cyc + 1;
         if (noc_msg_out != 4'd0) begin
            if (exp_q.size() == 0) begin
               check_eq("out_unexpected", 192'(noc_msg_out), 192'(0));
            end else begin
               e_word = exp_q.pop_front();
               check_eq("out_entry",
                        192'({noc_msg_out, noc_address_out, noc_data_out, noc_dest_id}),
                        192'(e_word[OW-1:0]));
               check_eq("out_cycle", 192'(cyc[15:0]), 192'(e_word[OW+15:OW]));
            end
         end
      end
   end

   function automatic logic tb_is_req(input logic [3:0] msg);
      return (msg == 4'd6) || (msg == 4'd7) || (msg == 4'd8);
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
      noc_msg_in      = '0;
      noc_address_in  = '0;
      noc_data_in     = '0;
      noc_src_id      = '0;
      ctrl_msg_in     = '0;
      ctrl_address_in = '0;
      ctrl_data_in    = '0;
      ctrl_dest_id    = '0;
      reqbuf_read     = 1'b0;
      respbuf_read    = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic expect_out(input logic [3:0] msg, input logic [31:0] addr,
                             input logic [127:0] data, input logic [2:0] dest, input int at);
      logic [15:0] at16;
      at16 = at[15:0];
      exp_q.push_back({at16, msg, addr, data, dest});
   endtask

   // NoC input for the coming cycle; requests meeting a full request FIFO expect a nack two cycles on.
   task automatic set_noc(input logic [3:0] msg, input logic [31:0] addr,
                          input logic [127:0] data, input logic [2:0] src);
      noc_msg_in     = msg;
      noc_address_in = addr;
      noc_data_in    = data;
      noc_src_id     = src;
      if (tb_is_req(msg)) begin
         if (req_model_q.size() < 4) req_model_q.push_back({src, msg, addr, data});
         else expect_out(4'd13, addr, 128'd0, src, cyc + 3);
      end else if (msg != 4'd0) begin
         resp_model_q.push_back({src, msg, addr, data});
      end
   endtask

   task automatic set_ctrl(input logic [3:0] msg, input logic [31:0] addr,
                           input logic [127:0] data, input logic [2:0] dest, input int lat);
      ctrl_msg_in     = msg;
      ctrl_address_in = addr;
      ctrl_data_in    = data;
      ctrl_dest_id    = dest;
      expect_out(msg, addr, data, dest, cyc + 1 + lat);
   endtask

   task automatic pop_req();
      check_eq("req_valid", 192'(reqbuf_valid), 192'(1));
      if (req_model_q.size() != 0) begin
         check_eq("req_head", 192'(reqbuf_data), 192'(req_model_q[0]));
         void'(req_model_q.pop_front());
      end
      reqbuf_read = 1'b1;
      step();
   endtask

   task automatic pop_resp();
      check_eq("resp_valid", 192'(respbuf_valid), 192'(1));
      if (resp_model_q.size() != 0) begin
         check_eq("resp_head", 192'(respbuf_data), 192'(resp_model_q[0]));
         void'(resp_model_q.pop_front());
      end
      respbuf_read = 1'b1;
      step();
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         step();
         n++;
      end
      check_eq("drain", 192'(exp_q.size()), 192'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0]   rmsg;
      logic [127:0] rdata;

      // Reset state, with intf_busy following packetizer_busy.
      packetizer_busy = 1'b1;
      #1 reset = 1'b0;
      #11;
      check_eq("rst_msg", 192'(noc_msg_out), 192'(0));
      check_eq("rst_addr", 192'(noc_address_out), 192'(0));
      check_eq("rst_data", 192'(noc_data_out), 192'(0));
      check_eq("rst_dest", 192'(noc_dest_id), 192'(2));
      check_eq("rst_req_flags", 192'({reqbuf_empty, reqbuf_full, reqbuf_valid}), 192'(3'b100));
      check_eq("rst_resp_flags", 192'({respbuf_empty, respbuf_full, respbuf_valid}), 192'(3'b100));
      check_eq("rst_busy_hi", 192'(intf_busy), 192'(1));
      packetizer_busy = 1'b0;
      #1;
      check_eq("rst_busy_lo", 192'(intf_busy), 192'(0));
      @(posedge clock);
      #1;
      reset  = 1'b1;
      mon_en = 1'b1;
      idle(2);

      // Mixed requests/responses: four requests fill the request FIFO, two responses queue.
      set_noc(4'd6,  32'h10000010, 128'd0, 3'd0); step();
      set_noc(4'd6,  32'h10000020, 128'd0, 3'd0); step();
      set_noc(4'd10, 32'h10000030, 128'hA5A5_0000_1111_2222_3333_4444_5555_6666, 3'd0); step();
      set_noc(4'd9,  32'h10000040, 128'd0, 3'd0); step();
      set_noc(4'd8,  32'h10000050, 128'd0, 3'd2); step();
      set_noc(4'd8,  32'h10000060, 128'd0, 3'd0); step();
      idle(2);
      check_eq("fill_req_full", 192'(reqbuf_full), 192'(1));
      check_eq("fill_req_valid", 192'(reqbuf_valid), 192'(1));
      check_eq("fill_req_head", 192'(reqbuf_data), 192'({3'd0, 4'd6, 32'h10000010, 128'd0}));
      check_eq("fill_resp_full", 192'(respbuf_full), 192'(0));
      check_eq("fill_resp_valid", 192'(respbuf_valid), 192'(1));

      // Overflowing request is nacked back to its sender.
      set_noc(4'd8, 32'h20002000, 128'd0, 3'd5); step();
      step();
      check_eq("nack_busy", 192'(intf_busy), 192'(1));
      step();
      check_eq("nack_busy_clear", 192'(intf_busy), 192'(0));
      wait_drain();

      // Controller bypass.
      set_ctrl(4'd3, 32'h40002000, 128'h10000000_20000000_30000000_40000000, 3'd3, 1); step();
      wait_drain();

      // Ctrl bypass and an overflow nack presented together.
      set_ctrl(4'd4, 32'h50005000, 128'hDEAD_BEEF, 3'd7, 1);
      set_noc(4'd8, 32'h20002000, 128'd0, 3'd0);
      step();
      wait_drain();

      // Nack preempts ctrl; later ctrl messages queue behind it.
      set_noc(4'd8, 32'h20002000, 128'd0, 3'd1); step();
      set_ctrl(4'd4, 32'h50005000, 128'd0, 3'd7, 2); step();
      set_ctrl(4'd1, 32'h44005500, 128'd0, 3'd4, 2); step();
      wait_drain();
      pop_resp();
      pop_resp();
      check_eq("resp_empty", 192'(respbuf_empty), 192'(1));
      check_eq("resp_invalid", 192'(respbuf_valid), 192'(0));

      // Backpressure: six busy cycles, three ctrl messages held back and released in order.
      idle(1);
      packetizer_busy = 1'b1;
      set_ctrl(4'd3, 32'h60000010, 128'h1, 3'd1, 7); step();
      set_ctrl(4'd4, 32'h60000020, 128'h2, 3'd2, 7); step();
      set_ctrl(4'd2, 32'h60000030, 128'h3, 3'd3, 7); step();
      check_eq("bp_hold_msg", 192'(noc_msg_out), 192'(0));
      check_eq("bp_busy", 192'(intf_busy), 192'(1));
      idle(3);
      packetizer_busy = 1'b0;
      #1;
      check_eq("bp_release_pending", 192'(intf_busy), 192'(1));
      wait_drain();
      check_eq("bp_done_busy", 192'(intf_busy), 192'(0));

      // Drain request FIFO, including a write and read on the same edge.
      pop_req();
      set_noc(4'd7, 32'h30003000, 128'h77, 3'd4); step();
      pop_req();
      check_eq("rw_same_edge_full", 192'(reqbuf_full), 192'(0));
      pop_req();
      pop_req();
      pop_req();
      check_eq("req_empty", 192'(reqbuf_empty), 192'(1));
      check_eq("req_invalid", 192'(reqbuf_valid), 192'(0));

      // A read on an empty FIFO is ignored and must not disturb later writes.
      reqbuf_read = 1'b1;
      step();
      check_eq("empty_read_empty", 192'(reqbuf_empty), 192'(1));
      check_eq("empty_read_full", 192'(reqbuf_full), 192'(0));
      set_noc(4'd6, 32'h00000055, 128'd0, 3'd6); step();
      idle(1);
      pop_req();
      check_eq("req_empty_again", 192'(reqbuf_empty), 192'(1));

      // Random responses through the response FIFO.
      for (int i = 0; i < 3; i++) begin
         case ($urandom_range(0, 2))
            0:       rmsg = 4'd9;
            1:       rmsg = 4'd10;
            default: rmsg = 4'd11;
         endcase
         rdata = {$urandom, $urandom, $urandom, $urandom};
         set_noc(rmsg, $urandom, rdata, 3'($urandom_range(0, 7)));
         step();
      end
      idle(2);
      for (int i = 0; i < 3; i++) pop_resp();
      check_eq("rand_resp_empty", 192'(respbuf_empty), 192'(1));

      // Asynchronous reset clears a non-empty FIFO without a clock edge.
      set_noc(4'd10, 32'h70007000, 128'h9, 3'd1); step();
      idle(1);
      check_eq("pre_async_valid", 192'(respbuf_valid), 192'(1));
      mon_en = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      check_eq("async_resp_empty", 192'(respbuf_empty), 192'(1));
      check_eq("async_dest", 192'(noc_dest_id), 192'(2));
      check_eq("async_msg", 192'(noc_msg_out), 192'(0));
      check_eq("final_pending", 192'(exp_q.size()), 192'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
